// File: rtl/sram_to_sram_like_data.sv
// sram_to_sram_like_data: turns single-cycle data SRAM requests into sram-like req/addr_ok/data_ok
// transactions, stalling the core until the response arrives and holding read data until release.
module sram_to_sram_like_data (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        d_stall,
  input  logic        longest_stall,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_DATA, DONE} state_t;
  state_t      state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  assign data_req        = data_sram_en & (state_q == IDLE);
  assign d_stall         = data_sram_en & (state_q != DONE);
  assign data_wr         = |data_sram_wen;
  assign data_addr       = data_sram_addr;
  assign data_wdata      = data_sram_wdata;
  assign data_sram_rdata = rdata_q;
  assign data_size = (data_sram_wen inside {4'b0001, 4'b0010, 4'b0100, 4'b1000}) ? 2'd0 :
                     (data_sram_wen inside {4'b0011, 4'b1100}) ? 2'd1 : 2'd2;
  // data_ok outside WAIT_DATA belongs to no outstanding request and is dropped
  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE:      state_d = (data_req & data_addr_ok) ? WAIT_DATA : IDLE;
      WAIT_DATA: begin
        state_d = data_data_ok ? DONE : WAIT_DATA;
        rdata_d = data_data_ok ? data_rdata : rdata_q;
      end
      DONE:      state_d = longest_stall ? DONE : IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_sram_to_sram_like_data.sv
// tb_sram_to_sram_like_data: random and directed stimulus checked every cycle against a transaction-level model.
module tb_sram_to_sram_like_data;
  logic        clk = 0;
  logic        resetn = 0;
  logic        data_sram_en = 0;
  logic [3:0]  data_sram_wen = 0;
  logic [31:0] data_sram_addr = 0;
  logic [31:0] data_sram_wdata = 0;
  logic [31:0] data_sram_rdata;
  logic        d_stall;
  logic        longest_stall = 0;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok = 0;
  logic        data_data_ok = 0;
  logic [31:0] data_rdata = 0;
  int checks = 0;
  int failures = 0;
  int handshakes = 0;
  sram_to_sram_like_data dut (
    .clk(clk), .resetn(resetn),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_rdata(data_sram_rdata), .d_stall(d_stall), .longest_stall(longest_stall),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );
  always #5 clk = ~clk;
  // Model: a request is either outstanding (accepted, awaiting data) or answered (held until release)
  logic        m_outstanding = 0;
  logic        m_answered = 0;
  logic [31:0] m_rdata = 0;
  function automatic logic [1:0] exp_size(input logic [3:0] w);
    if ($countones(w) == 1) return 2'd0;
    if (w == 4'b0011 || w == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_outstanding <= 0;
      m_answered <= 0;
      m_rdata <= 0;
    end else if (m_answered) begin
      if (!longest_stall) m_answered <= 0;
    end else if (m_outstanding) begin
      if (data_data_ok) begin
        m_outstanding <= 0;
        m_answered <= 1;
        m_rdata <= data_rdata;
      end
    end else if (data_sram_en && data_addr_ok) begin
      m_outstanding <= 1;
      handshakes <= handshakes + 1;
    end
  end
  always @(negedge clk) begin
    if (resetn) begin
      chk("d_stall", 32'(d_stall), 32'(data_sram_en && !m_answered));
      chk("data_req", 32'(data_req), 32'(data_sram_en && !m_answered && !m_outstanding));
      chk("data_wr", 32'(data_wr), 32'(data_sram_wen != 0));
      chk("data_size", 32'(data_size), 32'(exp_size(data_sram_wen)));
      chk("data_addr", data_addr, data_sram_addr);
      chk("data_wdata", data_wdata, data_sram_wdata);
      chk("rdata", data_sram_rdata, m_rdata);
    end
  end
  task automatic drive(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic aok, input logic dok, input logic [31:0] rd, input logic ls);
    @(posedge clk);
    #1;
    data_sram_en = en;
    data_sram_wen = wen;
    data_sram_addr = addr;
    data_sram_wdata = 32'hA5A5_0000 | addr[15:0];
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata = rd;
    longest_stall = ls;
  endtask
  logic [3:0] wen_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'h5, 4'h6};
  logic [3:0] size_w [5] = '{4'b0011, 4'b1100, 4'b1111, 4'b0101, 4'b0100};
  logic [1:0] size_e [5] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
  initial begin
    #12;
    @(negedge clk);
    chk("reset_rdata", data_sram_rdata, 32'h0);
    chk("reset_stall", 32'(d_stall), 32'h0);
    resetn = 1;
    // read, zero wait
    drive(1, 4'h0, 32'h1FC0_0010, 1, 0, 0, 0);
    @(negedge clk);
    chk("rd_stall_c1", 32'(d_stall), 32'h1);
    drive(1, 4'h0, 32'h1FC0_0010, 0, 1, 32'hDEAD_BEEF, 0);
    @(negedge clk);
    chk("rd_stall_c2", 32'(d_stall), 32'h1);
    drive(1, 4'h0, 32'h1FC0_0010, 0, 0, 0, 0);
    @(negedge clk);
    chk("rd_stall_c3", 32'(d_stall), 32'h0);
    chk("rd_data", data_sram_rdata, 32'hDEAD_BEEF);
    // byte store with address backpressure
    drive(1, 4'b0100, 32'h0000_0102, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bs_req_held", 32'(data_req), 32'h1);
      chk("bs_size", 32'(data_size), 32'h0);
      drive(1, 4'b0100, 32'h0000_0102, i == 2, 0, 0, 0);
    end
    drive(1, 4'b0100, 32'h0000_0102, 0, 1, 32'h1234_5678, 0);
    drive(1, 4'b0100, 32'h0000_0102, 0, 0, 0, 1);
    @(negedge clk);
    chk("bs_stall_drop", 32'(d_stall), 32'h0);
    // held by longest_stall
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'b0100, 32'h0000_0102, 1, 0, 0, 1);
      @(negedge clk);
      chk("ls_no_req", 32'(data_req), 32'h0);
      chk("ls_hold", data_sram_rdata, 32'h1234_5678);
    end
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    // size decode
    for (int i = 0; i < 5; i++) begin
      drive(0, size_w[i], 32'h40, 0, 0, 0, 0);
      @(negedge clk);
      chk("size_lit", 32'(data_size), 32'(size_e[i]));
    end
    // back-to-back reads
    handshakes = 0;
    drive(1, 4'h0, 32'h100, 1, 0, 0, 0);
    drive(1, 4'h0, 32'h100, 0, 1, 32'h1111_0001, 0);
    drive(1, 4'h0, 32'h100, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_r1", data_sram_rdata, 32'h1111_0001);
    drive(1, 4'h0, 32'h104, 1, 0, 0, 0);
    @(negedge clk);
    chk("b2b_req2", 32'(data_req), 32'h1);
    drive(1, 4'h0, 32'h104, 0, 1, 32'h2222_0002, 0);
    drive(0, 4'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("b2b_r2", data_sram_rdata, 32'h2222_0002);
    chk("b2b_handshakes", 32'(handshakes), 32'd2);
    // reset mid-flight
    drive(1, 4'h0, 32'h200, 1, 0, 0, 0);
    drive(0, 4'h0, 32'h200, 0, 0, 0, 0);
    resetn = 0;
    @(posedge clk);
    #1 resetn = 1;
    drive(0, 4'h0, 32'h200, 0, 1, 32'hBAD0_BAD0, 0);
    drive(0, 4'h0, 32'h200, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_rdata", data_sram_rdata, 32'h0);
    chk("rst_req", 32'(data_req), 32'h0);
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (!(data_sram_en && !m_answered) || !resetn) begin
        data_sram_en = ($urandom_range(0, 9) < 7);
        data_sram_wen = wen_tab[$urandom_range(0, 9)];
        data_sram_addr = $urandom;
        data_sram_wdata = $urandom;
      end
      data_addr_ok = $urandom_range(0, 1);
      data_data_ok = ($urandom_range(0, 9) < 4);
      data_rdata = $urandom;
      longest_stall = ($urandom_range(0, 9) < 3);
      resetn = ($urandom_range(0, 499) != 0);
    end
    resetn = 1;
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
